// File: rtl/sdram_chip_model.sv
// sdram_chip_model: memory-side responder for a single-chip SDR SDRAM command bus.
// It decodes bus commands, tracks the init sequence, open rows, mode register and
// timing windows per bank, and serves read/write bursts from an on-chip array.
// Protocol violations are latched in sticky error bits.
module sdram_chip_model #(
    parameter int MEM_AW = 16,
    parameter int T_RCD  = 2,
    parameter int T_RP   = 2,
    parameter int T_RFC  = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sd_cs_n,
    input  logic        sd_ras_n,
    input  logic        sd_cas_n,
    input  logic        sd_we_n,
    input  logic [1:0]  sd_ba,
    input  logic [12:0] sd_a,
    input  logic        sd_dqml,
    input  logic        sd_dqmh,
    input  logic [15:0] sd_dq_in,
    output logic [15:0] sd_dq_out,
    output logic        sd_dq_oe,
    output logic [12:0] mode_reg,
    output logic [15:0] refresh_cnt,
    output logic [4:0]  err
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'((T_RCD > 0) ? T_RCD - 1 : 0);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'((T_RP  > 0) ? T_RP  - 1 : 0);
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'((T_RFC > 0) ? T_RFC - 1 : 0);

    typedef enum logic [2:0] {
        ST_PWRUP, ST_PRE_DONE, ST_REF1, ST_REF2, ST_READY
    } init_state_t;

    // Saturating down-counter step for the timing windows.
    function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] x);
        return (x != '0) ? x - CNT_W'(1) : '0;
    endfunction

    // Column of burst word idx: the low bits selected by mask count (sequential)
    // or are XORed (interleave); upper column bits stay fixed.
    function automatic logic [8:0] burst_col(input logic [8:0] start, input logic [2:0] idx,
                                             input logic [2:0] mask, input logic interleave);
        logic [2:0] low;
        low = interleave ? ((start[2:0] ^ idx) & mask) : ((start[2:0] + idx) & mask);
        return (start & ~{6'b0, mask}) | {6'b0, low};
    endfunction

    // Array index keeps the low MEM_AW bits of {bank,row,col}.
    function automatic logic [MEM_AW-1:0] mem_index(input logic [1:0] ba, input logic [12:0] row,
                                                    input logic [8:0] col);
        logic [23:0] full;
        full = {ba, row, col};
        return MEM_AW'(full);
    endfunction

    // Command decode
    logic [2:0] cmd;
    logic       cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_lmr, cmd_nop;
    assign cmd     = {sd_ras_n, sd_cas_n, sd_we_n};
    assign cmd_act = !sd_cs_n && (cmd == 3'b011);
    assign cmd_rd  = !sd_cs_n && (cmd == 3'b101);
    assign cmd_wr  = !sd_cs_n && (cmd == 3'b100);
    assign cmd_pre = !sd_cs_n && (cmd == 3'b010);
    assign cmd_ref = !sd_cs_n && (cmd == 3'b001);
    assign cmd_lmr = !sd_cs_n && (cmd == 3'b000);
    assign cmd_nop = !(cmd_act || cmd_rd || cmd_wr || cmd_pre || cmd_ref || cmd_lmr);

    // State registers
    init_state_t      state_q, state_d;
    logic [3:0]       bank_open_q, bank_open_d;
    logic [12:0]      bank_row_q [4];
    logic [12:0]      bank_row_d [4];
    logic [CNT_W-1:0] rcd_cnt_q [4];
    logic [CNT_W-1:0] rcd_cnt_d [4];
    logic [CNT_W-1:0] rp_cnt_q [4];
    logic [CNT_W-1:0] rp_cnt_d [4];
    logic [CNT_W-1:0] rfc_cnt_q, rfc_cnt_d;
    logic [12:0]      mode_reg_q, mode_reg_d;
    logic [15:0]      refresh_cnt_q, refresh_cnt_d;
    logic [4:0]       err_q, err_d;
    logic             bst_active_q, bst_active_d;
    logic             bst_write_q, bst_write_d;
    logic [1:0]       bst_ba_q, bst_ba_d;
    logic [12:0]      bst_row_q, bst_row_d;
    logic [8:0]       bst_start_q, bst_start_d;
    logic [2:0]       bst_idx_q, bst_idx_d;
    logic [2:0]       bst_left_q, bst_left_d;
    logic             vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic             dqm_p0_q, dqm_p0_d, dqm_p1_q, dqm_p1_d;
    logic             oe_q, oe_d;
    logic [15:0]      dq_out_q, dq_out_d;
    logic [15:0]      dq_p0_q, dq_p1_q, dq_p2_q;
    logic [15:0]      mem [0:(1<<MEM_AW)-1];

    // Mode register fields
    logic [2:0] bl_mask;
    logic       ilv, cl3, single_wr;
    assign ilv       = mode_reg_q[3];
    assign cl3       = (mode_reg_q[6:4] != 3'd2);
    assign single_wr = mode_reg_q[9];

    // Burst length mask from the BL field; reserved codes fall back to 1.
    always_comb begin
        case (mode_reg_q[2:0])
            3'b001:  bl_mask = 3'd1;
            3'b010:  bl_mask = 3'd3;
            3'b011:  bl_mask = 3'd7;
            default: bl_mask = 3'd0;
        endcase
    end

    logic              issue, kill, rd_en, wr_en, out_vld;
    logic [1:0]        acc_ba;
    logic [12:0]       acc_row;
    logic [8:0]        acc_col;
    logic [MEM_AW-1:0] mem_addr;
    logic [1:0]        wr_be;
    assign mem_addr = mem_index(acc_ba, acc_row, acc_col);
    assign wr_be    = {!sd_dqmh, !sd_dqml};

    // Next-state: command effects, error flags, burst sequencing, read pipeline control.
    always_comb begin
        state_d       = state_q;
        bank_open_d   = bank_open_q;
        bank_row_d    = bank_row_q;
        rfc_cnt_d     = dec(rfc_cnt_q);
        for (int b = 0; b < 4; b++) begin
            rcd_cnt_d[b] = dec(rcd_cnt_q[b]);
            rp_cnt_d[b]  = dec(rp_cnt_q[b]);
        end
        mode_reg_d    = mode_reg_q;
        refresh_cnt_d = refresh_cnt_q;
        err_d         = err_q;
        bst_active_d  = bst_active_q;
        bst_write_d   = bst_write_q;
        bst_ba_d      = bst_ba_q;
        bst_row_d     = bst_row_q;
        bst_start_d   = bst_start_q;
        bst_idx_d     = bst_idx_q;
        bst_left_d    = bst_left_q;
        issue         = 1'b0;
        kill          = 1'b0;
        rd_en         = 1'b0;
        wr_en         = 1'b0;
        acc_ba        = bst_ba_q;
        acc_row       = bst_row_q;
        acc_col       = '0;
        vld_p0_d      = 1'b0;
        vld_p1_d      = vld_p0_q;
        vld_p2_d      = vld_p1_q;
        dqm_p0_d      = sd_dqml | sd_dqmh;
        dqm_p1_d      = dqm_p0_q;
        out_vld       = cl3 ? vld_p2_q : vld_p1_q;
        oe_d          = out_vld && !dqm_p1_q;
        dq_out_d      = out_vld ? (cl3 ? dq_p2_q : dq_p1_q) : dq_out_q;

        if (!cmd_nop && (rfc_cnt_q != '0)) err_d[4] = 1'b1;

        if (cmd_act) begin
            if (state_q != ST_READY) begin
                err_d[0] = 1'b1;
            end else begin
                if (bank_open_q[sd_ba]) err_d[2] = 1'b1;
                if (rp_cnt_q[sd_ba] != '0) err_d[4] = 1'b1;
                bank_open_d[sd_ba] = 1'b1;
                bank_row_d[sd_ba]  = sd_a;
                rcd_cnt_d[sd_ba]   = LD_RCD;
            end
        end

        if (cmd_rd || cmd_wr) begin
            if (state_q != ST_READY) begin
                err_d[0] = 1'b1;
            end else if (!bank_open_q[sd_ba]) begin
                err_d[1] = 1'b1;
            end else begin
                if (rcd_cnt_q[sd_ba] != '0) err_d[4] = 1'b1;
                issue = 1'b1;
            end
        end

        // The first all-bank precharge doubles as the first init step.
        if (cmd_pre && ((state_q == ST_READY) || ((state_q == ST_PWRUP) && sd_a[10]))) begin
            for (int b = 0; b < 4; b++) begin
                if (sd_a[10] || (sd_ba == 2'(b))) begin
                    bank_open_d[b] = 1'b0;
                    rp_cnt_d[b]    = LD_RP;
                end
            end
            if (bst_active_q && (sd_a[10] || (sd_ba == bst_ba_q))) kill = 1'b1;
            if (state_q == ST_PWRUP) state_d = ST_PRE_DONE;
        end

        if (cmd_ref && (state_q inside {ST_PRE_DONE, ST_REF1, ST_READY})) begin
            if (|bank_open_q) err_d[3] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (rp_cnt_q[b] != '0) err_d[4] = 1'b1;
            end
            refresh_cnt_d = refresh_cnt_q + 16'd1;
            rfc_cnt_d     = LD_RFC;
            if (state_q == ST_PRE_DONE) state_d = ST_REF1;
            if (state_q == ST_REF1)     state_d = ST_REF2;
        end

        if (cmd_lmr && ((state_q == ST_REF2) || (state_q == ST_READY))) begin
            mode_reg_d = sd_a;
            state_d    = ST_READY;
        end

        // A new access replaces any burst; otherwise the running burst advances one word.
        if (issue) begin
            acc_ba       = sd_ba;
            acc_row      = bank_row_q[sd_ba];
            acc_col      = sd_a[8:0];
            bst_ba_d     = sd_ba;
            bst_row_d    = bank_row_q[sd_ba];
            bst_start_d  = sd_a[8:0];
            bst_write_d  = cmd_wr;
            bst_idx_d    = 3'd1;
            bst_left_d   = (cmd_wr && single_wr) ? 3'd0 : bl_mask;
            bst_active_d = (bst_left_d != 3'd0);
            if (cmd_wr) begin
                wr_en    = 1'b1;
                vld_p1_d = 1'b0;
                vld_p2_d = 1'b0;
                oe_d     = 1'b0;
            end else begin
                rd_en    = 1'b1;
                vld_p0_d = 1'b1;
            end
        end else if (bst_active_q && !kill) begin
            acc_col      = burst_col(bst_start_q, bst_idx_q, bl_mask, ilv);
            bst_idx_d    = bst_idx_q + 3'd1;
            bst_left_d   = bst_left_q - 3'd1;
            bst_active_d = (bst_left_q > 3'd1);
            if (bst_write_q) begin
                wr_en = 1'b1;
            end else begin
                rd_en    = 1'b1;
                vld_p0_d = 1'b1;
            end
        end else if (kill) begin
            bst_active_d = 1'b0;
        end
    end

    // Control and output registers with async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_PWRUP;
            bank_open_q   <= '0;
            for (int b = 0; b < 4; b++) begin
                bank_row_q[b] <= '0;
                rcd_cnt_q[b]  <= '0;
                rp_cnt_q[b]   <= '0;
            end
            rfc_cnt_q     <= '0;
            mode_reg_q    <= '0;
            refresh_cnt_q <= '0;
            err_q         <= '0;
            bst_active_q  <= 1'b0;
            bst_write_q   <= 1'b0;
            bst_ba_q      <= '0;
            bst_row_q     <= '0;
            bst_start_q   <= '0;
            bst_idx_q     <= '0;
            bst_left_q    <= '0;
            vld_p0_q      <= 1'b0;
            vld_p1_q      <= 1'b0;
            vld_p2_q      <= 1'b0;
            dqm_p0_q      <= 1'b0;
            dqm_p1_q      <= 1'b0;
            oe_q          <= 1'b0;
            dq_out_q      <= '0;
        end else begin
            state_q       <= state_d;
            bank_open_q   <= bank_open_d;
            bank_row_q    <= bank_row_d;
            rcd_cnt_q     <= rcd_cnt_d;
            rp_cnt_q      <= rp_cnt_d;
            rfc_cnt_q     <= rfc_cnt_d;
            mode_reg_q    <= mode_reg_d;
            refresh_cnt_q <= refresh_cnt_d;
            err_q         <= err_d;
            bst_active_q  <= bst_active_d;
            bst_write_q   <= bst_write_d;
            bst_ba_q      <= bst_ba_d;
            bst_row_q     <= bst_row_d;
            bst_start_q   <= bst_start_d;
            bst_idx_q     <= bst_idx_d;
            bst_left_q    <= bst_left_d;
            vld_p0_q      <= vld_p0_d;
            vld_p1_q      <= vld_p1_d;
            vld_p2_q      <= vld_p2_d;
            dqm_p0_q      <= dqm_p0_d;
            dqm_p1_q      <= dqm_p1_d;
            oe_q          <= oe_d;
            dq_out_q      <= dq_out_d;
        end
    end

    // Byte-enabled array write, registered array read and the read-data delay line.
    always_ff @(posedge clk) begin
        if (wr_en && reset_n) begin
            if (wr_be[0]) mem[mem_addr][7:0]  <= sd_dq_in[7:0];
            if (wr_be[1]) mem[mem_addr][15:8] <= sd_dq_in[15:8];
        end
        if (rd_en) dq_p0_q <= mem[mem_addr];
        dq_p1_q <= dq_p0_q;
        dq_p2_q <= dq_p1_q;
    end

    assign sd_dq_out   = dq_out_q;
    assign sd_dq_oe    = oe_q;
    assign mode_reg    = mode_reg_q;
    assign refresh_cnt = refresh_cnt_q;
    assign err         = err_q;

endmodule
